// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite burst master turning single commands into SINGLE/INCR transfers
// Streams write data in via valid/ready, read data out as valid pulses; honours wait states and ERROR.

module ahb_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LAST, S_ERR} state_t;

  state_t                state;
  logic [1:0]            trans_q;
  logic [4:0]            beats_left;
  logic                  dp_active;
  logic                  dp_write;
  logic [4:0]            len_eff;
  logic                  addr_accept;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] next_addr;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == 5'd0)
      len_eff = 5'd1;
    else if (cmd_len > 5'(MAX_LEN))
      len_eff = 5'(MAX_LEN);
  end

  // A write beat without data waits: IDLE before a fresh NONSEQ, BUSY inside a burst.
  always_comb begin
    HTRANS = trans_q;
    if (HWRITE && trans_q[1] && !wdata_valid)
      HTRANS = (trans_q == TR_NONSEQ) ? TR_IDLE : TR_BUSY;
  end

  assign addr_accept = HTRANS[1] && HREADY;
  assign wdata_ready = addr_accept && HWRITE;
  assign resp_err    = (HRESP != 2'b00);
  assign next_addr   = HADDR + (ADDR_WIDTH'(1) << HSIZE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= S_IDLE;
      trans_q     <= TR_IDLE;
      beats_left  <= 5'd0;
      dp_active   <= 1'b0;
      dp_write    <= 1'b0;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'b010;
      HBURST      <= BURST_SINGLE;
      HWDATA      <= '0;
      cmd_ready   <= 1'b1;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      rdata_valid <= 1'b0;

      if (dp_active && HREADY) begin
        dp_active <= 1'b0;
        if (!dp_write && !resp_err) begin
          rdata       <= HRDATA;
          rdata_valid <= 1'b1;
        end
      end

      if (addr_accept) begin
        dp_active  <= 1'b1;
        dp_write   <= HWRITE;
        beats_left <= beats_left - 5'd1;
        if (HWRITE)
          HWDATA <= wdata;
        if (beats_left == 5'd1) begin
          trans_q <= TR_IDLE;
        end else begin
          HADDR   <= next_addr;
          // Crossing a 1 KB boundary restarts the burst with NONSEQ.
          trans_q <= (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
        end
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state      <= S_ACTIVE;
            cmd_ready  <= 1'b0;
            HADDR      <= cmd_addr;
            HWRITE     <= cmd_write;
            HSIZE      <= cmd_size;
            HBURST     <= (len_eff == 5'd1) ? BURST_SINGLE : BURST_INCR;
            beats_left <= len_eff;
            trans_q    <= TR_NONSEQ;
          end
        end
        S_ACTIVE: begin
          if (dp_active && resp_err) begin
            trans_q <= TR_IDLE;
            if (HREADY) begin
              state     <= S_IDLE;
              dp_active <= 1'b0;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
              err       <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (addr_accept && beats_left == 5'd1) begin
            state <= S_LAST;
          end
        end
        S_LAST: begin
          if (dp_active && resp_err && !HREADY) begin
            state <= S_ERR;
          end else if (dp_active && HREADY) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            err       <= resp_err;
          end
        end
        S_ERR: begin
          if (HREADY) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            err       <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
